// File: rtl/rv32m_div_unit.sv
// RV32M integer divide/remainder unit: restoring divider, one quotient bit per
// cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
// Ports: clk, rst (async, active-high), start/op/A/B request, flush abort,
//        busy (not idle), done (one-cycle result pulse), Y (result).
module rv32m_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Y
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [N-1:0] LAST = N'(N - 1);
    localparam logic [N-1:0] MIN  = {1'b1, {(N-1){1'b0}}};

    state_t       state_q;
    logic         busy_q;
    logic         done_q;
    logic         sel_rem_q;
    logic         a_neg_q;
    logic         b_neg_q;
    logic [N-1:0] quo_q;
    logic [N-1:0] dvs_q;
    logic [N-1:0] rem_q;
    logic [N-1:0] cnt_q;
    logic [N-1:0] y_q;

    logic         is_signed;
    logic         a_neg;
    logic         b_neg;
    logic [N-1:0] a_abs;
    logic [N-1:0] b_abs;
    logic         ovf;
    logic [N:0]   rem_sh;
    logic [N:0]   diff;
    logic         ge;
    logic [N-1:0] rem_d;
    logic [N-1:0] quo_d;
    logic [N-1:0] q_fix;
    logic [N-1:0] r_fix;
    logic [N-1:0] y_d;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & A[N-1];
        b_neg     = is_signed & B[N-1];
        a_abs     = a_neg ? -A : A;
        b_abs     = b_neg ? -B : B;
        ovf       = is_signed && (A == MIN) && (B == '1);
        // Shifted remainder may carry into bit N; in that case it already
        // exceeds any N-bit divisor, so the subtract always succeeds.
        rem_sh    = {rem_q, quo_q[N-1]};
        diff      = rem_sh - {1'b0, dvs_q};
        ge        = rem_sh[N] | ~diff[N];
        rem_d     = ge ? diff[N-1:0] : rem_sh[N-1:0];
        quo_d     = {quo_q[N-2:0], ge};
        q_fix     = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
        r_fix     = a_neg_q ? -rem_q : rem_q;
        y_d       = sel_rem_q ? r_fix : q_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_rem_q <= op[1];
                        a_neg_q   <= a_neg;
                        b_neg_q   <= b_neg;
                        quo_q     <= a_abs;
                        dvs_q     <= b_abs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (B == '0) begin
                            y_q     <= op[1] ? A : '1;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (ovf) begin
                            y_q     <= op[1] ? '0 : A;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + N'(1);
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    y_q     <= y_d;
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Y    = y_q;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Self-checking bench for rv32m_div_unit: vector table through a result
// scoreboard, plus flush, held-start and mid-operation reset sequences.
module tb_rv32m_div_unit;

    localparam int N = 32;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] Y;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    rv32m_div_unit #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .Y     (Y)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] yv, input int lat);
        int cyc;
        logic [31:0] e;
        @(negedge clk);
        op    = o;
        A     = av;
        B     = bv;
        start = 1'b1;
        exp_q.push_back(yv);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        check({nm, "_busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, "_done_seen"}, 32'(done), 32'd1);
        e = exp_q.pop_front();
        if (done) begin
            check({nm, "_y"}, Y, e);
            check({nm, "_lat"}, 32'(cyc), 32'(lat));
            @(posedge clk);
            #1;
            check({nm, "_after"}, {30'd0, busy, done}, 32'd0);
            check({nm, "_hold"}, Y, e);
        end
    endtask

    initial begin
        int cyc;
        int dcnt;
        int dcyc[2];
        logic [31:0] e;

        vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         34};
        vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          34};
        vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vecs[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vecs[4]  = '{DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{REMU, 32'd5,          32'd0,          32'd5,          1};
        vecs[6]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[7]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[8]  = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
        vecs[9]  = '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        vecs[10] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        vecs[11] = '{REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          34};
        vecs[12] = '{DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  34};
        vecs[13] = '{DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[14] = '{REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        vecs[15] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        vecs[16] = '{REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
        vecs[17] = '{REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        flush = 1'b0;
        #22;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_y", Y, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                   vecs[i].b, vecs[i].y, vecs[i].lat);
        end

        // Flush mid-operation, then a fresh REMU.
        @(negedge clk);
        op    = DIVU;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        check("flush_c12_done", 32'(done), 32'd0);
        op    = REMU;
        start = 1'b1;
        exp_q.push_back(32'd2);
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        while (!done && cyc < 120) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("flush_new_done", 32'(done), 32'd1);
        e = exp_q.pop_front();
        check("flush_new_y", Y, e);
        check("flush_new_lat", 32'(cyc), 32'd46);
        @(posedge clk);
        #1;

        // start held high across two operations.
        @(negedge clk);
        op    = DIVU;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd14);
        dcnt  = 0;
        dcyc  = '{0, 0};
        @(posedge clk);
        #1;
        cyc = 1;
        while (cyc <= 69) begin
            if (done) begin
                if (dcnt < 2) dcyc[dcnt] = cyc;
                dcnt++;
                e = exp_q.pop_front();
                check("held_y", Y, e);
            end
            if (cyc == 35) check("held_idle35", 32'(busy), 32'd0);
            if (cyc == 36) check("held_busy36", 32'(busy), 32'd1);
            if (cyc == 69) start = 1'b0;
            if (cyc < 69) begin
                @(posedge clk);
                #1;
            end
            cyc++;
        end
        check("held_count", 32'(dcnt), 32'd2);
        check("held_first", 32'(dcyc[0]), 32'd34);
        check("held_second", 32'(dcyc[1]), 32'd69);
        @(posedge clk);
        #1;
        check("held_end_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        op    = DIVU;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", Y, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
